fetch_unit: RTL and testbench

- Front-end fetch stage that sits directly upstream of instruction_queue.
- Owns the fetch PC and issues sequential word reads to a fixed-latency pipelined instruction BRAM.
- Buffers returned words together with their PCs, and presents them on a valid/ready handshake. valid_out drives the queue's valid_in; ready_in comes from the queue's ready_out.
- Accepts a redirect from the commit/branch logic; a redirect flushes everything in flight.

---
 rtl/fetch_unit.sv | 202 ++++++++++++++++++++
 tb/tb_fetch_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: front-end fetch stage feeding instruction_queue.
// Owns the fetch PC, issues sequential word reads to a fixed-latency
// pipelined instruction BRAM, tracks requests in flight, and buffers the
// returned words with their PCs in a show-ahead FIFO behind a valid/ready
// handshake. A redirect flushes everything in flight and restarts fetch.
// Optional build macro: FETCH_HALT_EN -- stop fetching once an ECALL or
// EBREAK word lands in the FIFO, until the next redirect or reset.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_LATENCY = 2,
  parameter int          BUF_DEPTH   = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        redirect_valid_in,
  input  logic [31:0] redirect_pc_in,
  input  logic        ready_in,
  input  logic [31:0] imem_data_in,
  output logic        imem_en_out,
  output logic [31:0] imem_addr_out,
  output logic        valid_out,
  output logic [31:0] instruction_out,
  output logic [31:0] pc_out
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int OCC_W = $clog2(BUF_DEPTH + MEM_LATENCY + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_START  = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [31:0] fetch_pc_q, fetch_pc_d;

  // In-flight shadow of the BRAM pipeline: stage i holds the request that
  // was sampled i+1 edges ago.
  logic        infl_vld_q [MEM_LATENCY];
  logic [31:0] infl_pc_q  [MEM_LATENCY];

  // Return FIFO storage and bookkeeping.
  logic [31:0]      fifo_instr_q [BUF_DEPTH];
  logic [31:0]      fifo_pc_q    [BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             push;
  logic             pop;
  logic             halt_push;
  logic [OCC_W-1:0] inflight_count;
  logic [OCC_W-1:0] occupancy;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // The oldest in-flight stage lines up with the cycle its data is on the bus.
  assign push = infl_vld_q[MEM_LATENCY-1];
  assign pop  = valid_out && ready_in;

`ifdef FETCH_HALT_EN
  // A system-call/breakpoint word landing in the FIFO stops further fetch;
  // the request in that same cycle is suppressed too.
  assign halt_push = push &&
                     ((imem_data_in == 32'h0000_0073) ||
                      (imem_data_in == 32'h0010_0073));
`else
  assign halt_push = 1'b0;
`endif

  // Count requests still travelling through the BRAM pipeline.
  always_comb begin
    inflight_count = '0;
    for (int i = 0; i < MEM_LATENCY; i++) begin
      inflight_count = inflight_count + OCC_W'(infl_vld_q[i]);
    end
    occupancy = OCC_W'(count_q) + inflight_count;
  end

  // FSM state register.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= ST_START;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; a redirect always lands in FETCH.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_START:  state_d = ST_FETCH;
      ST_FETCH: begin
`ifdef FETCH_HALT_EN
        if (halt_push) begin
          state_d = ST_HALTED;
        end
`endif
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_START;
    endcase
    if (redirect_valid_in) begin
      state_d = ST_FETCH;
    end
  end

  // FSM output: issue a read only while fetching and while the words already
  // owed (buffered plus in flight) leave room in the FIFO. Pops in the same
  // cycle are deliberately not credited.
  always_comb begin
    imem_en_out = 1'b0;
    if (rst_in && (state_q == ST_FETCH) && !redirect_valid_in && !halt_push &&
        (occupancy < OCC_W'(BUF_DEPTH))) begin
      imem_en_out = 1'b1;
    end
  end

  assign imem_addr_out = fetch_pc_q;

  // Next fetch PC: redirect target (word aligned) or sequential advance.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid_in) begin
      fetch_pc_d = redirect_pc_in & 32'hFFFF_FFFC;
    end else if (imem_en_out) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  // Fetch PC register.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      fetch_pc_q <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // In-flight valid bits; a flush drops every outstanding response.
  always_ff @(posedge clk_in) begin
    if (!rst_in || redirect_valid_in) begin
      for (int i = 0; i < MEM_LATENCY; i++) begin
        infl_vld_q[i] <= 1'b0;
      end
    end else begin
      infl_vld_q[0] <= imem_en_out;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        infl_vld_q[i] <= infl_vld_q[i-1];
      end
    end
  end

  // In-flight PCs travel alongside their valid bits; no reset needed.
  always_ff @(posedge clk_in) begin
    infl_pc_q[0] <= fetch_pc_q;
    for (int i = 1; i < MEM_LATENCY; i++) begin
      infl_pc_q[i] <= infl_pc_q[i-1];
    end
  end

  // FIFO pointer and count next-state.
  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // FIFO bookkeeping registers; a redirect empties the buffer.
  always_ff @(posedge clk_in) begin
    if (!rst_in || redirect_valid_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage write; contents are qualified by count, so no reset.
  always_ff @(posedge clk_in) begin
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= imem_data_in;
      fifo_pc_q[wr_ptr_q]    <= infl_pc_q[MEM_LATENCY-1];
    end
  end

  // Show-ahead head; outputs read as zero while the buffer is empty.
  assign valid_out       = (count_q != '0);
  assign instruction_out = valid_out ? fifo_instr_q[rd_ptr_q] : 32'h0;
  assign pc_out          = valid_out ? fifo_pc_q[rd_ptr_q]    : 32'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed, table-driven bench for fetch_unit with a
// behavioural pipelined BRAM (mem[i] = 0x1000 + i).
module tb_fetch_unit;

  localparam int L   = 2;
  localparam int BUF = 4;

  logic        clk = 1'b0;
  logic        rst_in = 1'b0;
  logic        redirect_valid_in = 1'b0;
  logic [31:0] redirect_pc_in = 32'h0;
  logic        ready_in = 1'b1;
  logic [31:0] imem_data_in;
  logic        imem_en_out;
  logic [31:0] imem_addr_out;
  logic        valid_out;
  logic [31:0] instruction_out;
  logic [31:0] pc_out;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .MEM_LATENCY(L),
    .BUF_DEPTH  (BUF)
  ) dut (
    .clk_in           (clk),
    .rst_in           (rst_in),
    .redirect_valid_in(redirect_valid_in),
    .redirect_pc_in   (redirect_pc_in),
    .ready_in         (ready_in),
    .imem_data_in     (imem_data_in),
    .imem_en_out      (imem_en_out),
    .imem_addr_out    (imem_addr_out),
    .valid_out        (valid_out),
    .instruction_out  (instruction_out),
    .pc_out           (pc_out)
  );

  // Behavioural BRAM: request sampled at edge t is on the bus for edge t+L.
  bit          halt_mode = 1'b0;
  logic [31:0] pipe [L];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (halt_mode && a == 32'h8) return 32'h0000_0073;
    return 32'h1000 + (a >> 2);
  endfunction

  always @(posedge clk) begin
    pipe[0] <= imem_en_out ? mem_word(imem_addr_out) : 32'hDEAD_BEEF;
    for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
  end
  assign imem_data_in = pipe[L-1];

  int n_cmp = 0;
  int n_bad = 0;
  int outstanding = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs after the falling edge, then let outputs settle.
  // Also checks that words owed (requested but not yet consumed) never exceed
  // the buffer depth, then accounts for this cycle's request and pop.
  task automatic apply(input logic rst, input logic redir, input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    rst_in = rst;
    redirect_valid_in = redir;
    redirect_pc_in = rpc;
    ready_in = rdy;
    #1;
    n_cmp++;
    if (outstanding > BUF) begin
      n_bad++;
      $display("FAIL occupancy: got %0d want <= %0d", outstanding, BUF);
    end
    if (!rst_in || redirect_valid_in) outstanding = 0;
    else outstanding = outstanding + int'(imem_en_out) - int'(valid_out && ready_in);
  endtask

  task automatic check_out(input int idx, input logic en, input logic [31:0] addr,
                           input logic v, input logic [31:0] pc);
    chk("imem_en", idx, {31'b0, imem_en_out}, {31'b0, en});
    chk("imem_addr", idx, imem_addr_out, addr);
    chk("valid", idx, {31'b0, valid_out}, {31'b0, v});
    chk("pc", idx, pc_out, v ? pc : 32'h0);
    chk("instr", idx, instruction_out, v ? mem_word(pc) : 32'h0);
  endtask

  typedef struct {
    logic        rst;
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        en;
    logic [31:0] addr;
    logic        v;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic redir, input logic [31:0] rpc, input logic rdy,
                     input logic en, input logic [31:0] addr, input logic v, input logic [31:0] pc);
    vec_t r;
    r.rst = rst; r.redir = redir; r.rpc = rpc; r.rdy = rdy;
    r.en = en; r.addr = addr; r.v = v; r.pc = pc;
    tbl.push_back(r);
  endtask

  initial begin
    // Reset held across three edges (the first edge precedes row 0).
    add(0, 0, 0, 1,   0, 32'h0, 0, 0);
    add(0, 0, 0, 1,   0, 32'h0, 0, 0);
    // Release: START for one cycle, then first request at 0x0.
    add(1, 0, 0, 1,   0, 32'h0, 0, 0);
    add(1, 0, 0, 1,   1, 32'h0, 0, 0);
    add(1, 0, 0, 1,   1, 32'h4, 0, 0);
    add(1, 0, 0, 1,   1, 32'h8, 0, 0);
    // Streaming: one word per cycle, pcs 0x0..0x3C.
    for (int i = 0; i < 16; i++) add(1, 0, 0, 1,   1, 32'((i + 3) * 4), 1, 32'(i * 4));
    // Backpressure for 10 cycles with 0x40 at the head.
    add(1, 0, 0, 0,   1, 32'h4C, 1, 32'h40);
    for (int i = 0; i < 9; i++) add(1, 0, 0, 0,   0, 32'h50, 1, 32'h40);
    // Release: drain the full buffer, then refill.
    add(1, 0, 0, 1,   0, 32'h50, 1, 32'h40);
    add(1, 0, 0, 1,   1, 32'h50, 1, 32'h44);
    add(1, 0, 0, 1,   1, 32'h54, 1, 32'h48);
    add(1, 0, 0, 1,   1, 32'h58, 1, 32'h4C);
    for (int i = 0; i < 4; i++) add(1, 0, 0, 1,   1, 32'h5C + 32'(4 * i), 1, 32'h50 + 32'(4 * i));
    // Redirect to 0x103 with 0x64/0x68 in flight; they must never appear.
    add(1, 1, 32'h103, 1,   0, 32'h6C, 1, 32'h60);
    add(1, 0, 0, 1,   1, 32'h100, 0, 0);
    add(1, 0, 0, 1,   1, 32'h104, 0, 0);
    add(1, 0, 0, 1,   1, 32'h108, 0, 0);
    for (int i = 0; i < 4; i++) add(1, 0, 0, 1,   1, 32'h10C + 32'(4 * i), 1, 32'h100 + 32'(4 * i));
    // Stall until three entries are buffered, then reset for one cycle.
    add(1, 0, 0, 0,   1, 32'h11C, 1, 32'h110);
    add(1, 0, 0, 0,   0, 32'h120, 1, 32'h110);
    add(0, 0, 0, 0,   0, 32'h120, 1, 32'h110);
    add(1, 0, 0, 1,   0, 32'h0, 0, 0);
    add(1, 0, 0, 1,   1, 32'h0, 0, 0);
    add(1, 0, 0, 1,   1, 32'h4, 0, 0);
    add(1, 0, 0, 1,   1, 32'h8, 0, 0);
    add(1, 0, 0, 1,   1, 32'hC, 1, 32'h0);
    add(1, 0, 0, 1,   1, 32'h10, 1, 32'h4);

    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].redir, tbl[i].rpc, tbl[i].rdy);
      check_out(i, tbl[i].en, tbl[i].addr, tbl[i].v, tbl[i].pc);
    end

    // Redirect while stalled with a full buffer, to a PC that wraps past 2^32.
    for (int i = 0; i < 4; i++) apply(1, 0, 0, 0);
    apply(1, 1, 32'hFFFF_FFFA, 0);
    chk("wrap_redir_en", 100, {31'b0, imem_en_out}, 32'h0);
    apply(1, 0, 0, 1);
    check_out(101, 1, 32'hFFFF_FFF8, 0, 0);
    apply(1, 0, 0, 1);
    check_out(102, 1, 32'hFFFF_FFFC, 0, 0);
    apply(1, 0, 0, 1);
    check_out(103, 1, 32'h0, 0, 0);
    apply(1, 0, 0, 1);
    check_out(104, 1, 32'h4, 1, 32'hFFFF_FFF8);
    apply(1, 0, 0, 1);
    check_out(105, 1, 32'h8, 1, 32'hFFFF_FFFC);
    apply(1, 0, 0, 1);
    check_out(106, 1, 32'hC, 1, 32'h0);

    // Reset and redirect in the same cycle: reset wins.
    apply(0, 1, 32'h200, 1);
    chk("rst_redir_en", 110, {31'b0, imem_en_out}, 32'h0);
    apply(1, 0, 0, 1);
    check_out(111, 0, 32'h0, 0, 0);
    apply(1, 0, 0, 1);
    check_out(112, 1, 32'h0, 0, 0);

`ifdef FETCH_HALT_EN
    begin
      int n_en;
      logic [31:0] got_pc[$];
      logic [31:0] got_ins[$];
      logic [31:0] exp_pc [4];
      logic [31:0] exp_ins [4];
      exp_pc  = '{32'h0, 32'h4, 32'h8, 32'hC};
      exp_ins = '{32'h1000, 32'h1001, 32'h0000_0073, 32'h1003};
      halt_mode = 1'b1;
      apply(0, 0, 0, 1);
      apply(0, 0, 0, 1);
      n_en = 0;
      for (int c = 0; c < 20; c++) begin
        apply(1, 0, 0, 1);
        if (imem_en_out) n_en++;
        if (valid_out) begin
          got_pc.push_back(pc_out);
          got_ins.push_back(instruction_out);
        end
      end
      chk("halt_req_count", 120, 32'(n_en), 32'd4);
      chk("halt_word_count", 121, 32'(got_pc.size()), 32'd4);
      for (int k = 0; k < 4; k++) begin
        if (k < got_pc.size()) begin
          chk("halt_pc", 122 + k, got_pc[k], exp_pc[k]);
          chk("halt_ins", 122 + k, got_ins[k], exp_ins[k]);
        end
      end
      apply(1, 1, 32'h40, 1);
      chk("halt_redir_en", 130, {31'b0, imem_en_out}, 32'h0);
      apply(1, 0, 0, 1);
      check_out(131, 1, 32'h40, 0, 0);
      apply(1, 0, 0, 1);
      apply(1, 0, 0, 1);
      apply(1, 0, 0, 1);
      check_out(134, 1, 32'h4C, 1, 32'h40);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
